// File: rtl/bot_snapshot.sv
// Atomic snapshot of the Rojobot register set with interrupt, overrun and ack tracking.
// Optional acknowledge timeout enabled by defining BOT_SNAP_TIMEOUT_EN.
module bot_snapshot #(
  parameter int unsigned PULSE_W     = 2,
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned TO_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UpdSysRegs,
  input  logic [7:0] LocXIn,
  input  logic [7:0] LocYIn,
  input  logic [7:0] BotInfoIn,
  input  logic [7:0] SensorsIn,
  input  logic [7:0] LMDistIn,
  input  logic [7:0] RMDistIn,
  input  logic       IntAck,
  input  logic       ClearOvr,
  output logic [7:0] LocX,
  output logic [7:0] LocY,
  output logic [7:0] BotInfo,
  output logic [7:0] Sensors,
  output logic [7:0] LMDist,
  output logic [7:0] RMDist,
  output logic       BotInterrupt,
  output logic       SnapValid,
  output logic       Overrun,
  output logic [7:0] OvrCnt,
  output logic       TimedOut
);

  typedef enum logic [1:0] {IDLE, IRQ, WAIT_ACK} state_e;

  localparam logic [3:0] PW = 4'(PULSE_W - 1);

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [5:0][7:0] snap_q, snap_d;
  logic            irq_q, irq_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic [7:0]      ocnt_q, ocnt_d;
  logic            tout_q, tout_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic            ovr_ev;
  logic [5:0][7:0] snap_in;

`ifdef BOT_SNAP_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ACK_TIMEOUT, TO_W};
`endif

  assign snap_in = {RMDistIn, LMDistIn, SensorsIn,
                    BotInfoIn, LocYIn, LocXIn};
  assign ovr_ev  = UpdSysRegs && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    irq_d   = irq_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ocnt_d  = ocnt_q;
    tout_d  = tout_q;
    pcnt_d  = pcnt_q;
`ifdef BOT_SNAP_TIMEOUT_EN
    to_d    = to_q;
`endif
    // Clear first so a coincident overrun or timeout lands on top
    if (ClearOvr) begin
      ovr_d  = 1'b0;
      ocnt_d = 8'h00;
      tout_d = 1'b0;
    end
    if (ovr_ev) begin
      pend_d = 1'b1;
      ovr_d  = 1'b1;
      if (ocnt_d != 8'hFF) ocnt_d = ocnt_d + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (UpdSysRegs || pend_q) begin
          snap_d  = snap_in;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          irq_d   = 1'b1;
          pcnt_d  = PW;
          state_d = IRQ;
        end
      end
      IRQ: begin
        if (IntAck) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end else if (pcnt_q == 4'd0) begin
          irq_d   = 1'b0;
          state_d = WAIT_ACK;
`ifdef BOT_SNAP_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          pcnt_d = pcnt_q - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (IntAck) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
`ifdef BOT_SNAP_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      snap_q  <= '0;
      irq_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ocnt_q  <= 8'h00;
      tout_q  <= 1'b0;
      pcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      irq_q   <= irq_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ocnt_q  <= ocnt_d;
      tout_q  <= tout_d;
      pcnt_q  <= pcnt_d;
    end
  end

`ifdef BOT_SNAP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_q <= '0;
    else      to_q <= to_d;
  end
`endif

  assign LocX         = snap_q[0];
  assign LocY         = snap_q[1];
  assign BotInfo      = snap_q[2];
  assign Sensors      = snap_q[3];
  assign LMDist       = snap_q[4];
  assign RMDist       = snap_q[5];
  assign BotInterrupt = irq_q;
  assign SnapValid    = valid_q;
  assign Overrun      = ovr_q;
  assign OvrCnt       = ocnt_q;
  assign TimedOut     = tout_q;

endmodule

// File: tb/tb_bot_snapshot.sv
// Self-checking bench for bot_snapshot: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_bot_snapshot;

  localparam int PW = 2;
`ifdef BOT_SNAP_TIMEOUT_EN
  localparam int ATO   = 50;
  localparam bit TO_EN = 1'b1;
`else
  localparam int ATO   = 1000000;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic upd = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [7:0] lxi = 0, lyi = 0, bii = 0, sni = 0, lmi = 0, rmi = 0;
  logic [7:0] lx, ly, bi, sn, lm, rm, oc;
  logic irq, sv, ovr, to;

  int checks = 0, passed = 0;

  bot_snapshot #(.PULSE_W(PW), .ACK_TIMEOUT(ATO), .TO_W(20)) dut (
    .clk(clk), .rst(rst), .UpdSysRegs(upd),
    .LocXIn(lxi), .LocYIn(lyi), .BotInfoIn(bii),
    .SensorsIn(sni), .LMDistIn(lmi), .RMDistIn(rmi),
    .IntAck(ack), .ClearOvr(clr),
    .LocX(lx), .LocY(ly), .BotInfo(bi), .Sensors(sn),
    .LMDist(lm), .RMDist(rm), .BotInterrupt(irq),
    .SnapValid(sv), .Overrun(ovr), .OvrCnt(oc), .TimedOut(to)
  );

  always #5 clk = ~clk;

  // Behavioural model: "busy" means a snapshot is awaiting acknowledge
  bit       m_busy, m_pend, m_valid, m_ovr, m_tout;
  int       m_irq_left, m_wait, m_ocnt;
  logic [7:0] m_snap[6];

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_valid = 0; m_ovr = 0; m_tout = 0;
    m_irq_left = 0; m_wait = 0; m_ocnt = 0;
    for (int k = 0; k < 6; k++) m_snap[k] = 8'h00;
  endtask

  task automatic model_step();
    if (clr) begin m_ovr = 0; m_ocnt = 0; m_tout = 0; end
    if (!m_busy) begin
      if (upd || m_pend) begin
        m_snap[0] = lxi; m_snap[1] = lyi; m_snap[2] = bii;
        m_snap[3] = sni; m_snap[4] = lmi; m_snap[5] = rmi;
        m_valid = 1; m_pend = 0; m_busy = 1; m_irq_left = PW;
      end
    end else begin
      if (upd) begin
        m_pend = 1; m_ovr = 1;
        if (m_ocnt < 255) m_ocnt++;
      end
      if (ack) begin
        m_busy = 0; m_irq_left = 0;
      end else if (m_irq_left > 0) begin
        m_irq_left--; m_wait = 0;
      end else begin
        m_wait++;
        if (TO_EN && m_wait == ATO) begin m_tout = 1; m_busy = 0; end
      end
    end
  endtask

  function automatic logic [59:0] exp_vec();
    return {m_snap[0], m_snap[1], m_snap[2], m_snap[3], m_snap[4],
            m_snap[5], logic'(m_busy && m_irq_left > 0), logic'(m_valid),
            logic'(m_ovr), 8'(m_ocnt), logic'(m_tout)};
  endfunction

  function automatic logic [59:0] dut_vec();
    return {lx, ly, bi, sn, lm, rm, irq, sv, ovr, oc, to};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic u, input logic a, input logic c);
    upd = u; ack = a; clr = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
    upd = 0; ack = 0; clr = 0;
  endtask

  task automatic do_reset();
    rst = 0; upd = 0; ack = 0; clr = 0;
    lxi = 0; lyi = 0; bii = 0; sni = 0; lmi = 0; rmi = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    logic u, a, c;
    logic [7:0] lx, sn;
    logic [7:0] e_lx, e_sn;
    logic e_irq, e_val, e_ovr;
    logic [7:0] e_cnt;
  } row_t;

  row_t tbl[12];

  initial begin
    int hi, bad, n;
    tbl[0]  = '{1, 0, 0, 8'h12, 8'hA5, 8'h12, 8'hA5, 1, 1, 0, 8'd0};
    tbl[1]  = '{0, 0, 0, 8'hFF, 8'hFF, 8'h12, 8'hA5, 1, 1, 0, 8'd0};
    tbl[2]  = '{0, 0, 0, 8'hFF, 8'hFF, 8'h12, 8'hA5, 0, 1, 0, 8'd0};
    tbl[3]  = '{1, 0, 0, 8'h30, 8'hFF, 8'h12, 8'hA5, 0, 1, 1, 8'd1};
    tbl[4]  = '{1, 0, 0, 8'h31, 8'hFF, 8'h12, 8'hA5, 0, 1, 1, 8'd2};
    tbl[5]  = '{0, 1, 0, 8'h31, 8'hFF, 8'h12, 8'hA5, 0, 1, 1, 8'd2};
    tbl[6]  = '{0, 0, 0, 8'h31, 8'hFF, 8'h31, 8'hFF, 1, 1, 1, 8'd2};
    tbl[7]  = '{0, 0, 0, 8'h00, 8'h00, 8'h31, 8'hFF, 1, 1, 1, 8'd2};
    tbl[8]  = '{0, 0, 0, 8'h00, 8'h00, 8'h31, 8'hFF, 0, 1, 1, 8'd2};
    tbl[9]  = '{0, 1, 0, 8'h00, 8'h00, 8'h31, 8'hFF, 0, 1, 1, 8'd2};
    tbl[10] = '{0, 1, 0, 8'h00, 8'h00, 8'h31, 8'hFF, 0, 1, 1, 8'd2};
    tbl[11] = '{0, 0, 1, 8'h00, 8'h00, 8'h31, 8'hFF, 0, 1, 0, 8'd0};

    do_reset();
    @(negedge clk);
    chk("reset_state", dut_vec(), 60'd0);

    for (int i = 0; i < 12; i++) begin
      lxi = tbl[i].lx; sni = tbl[i].sn;
      step(tbl[i].u, tbl[i].a, tbl[i].c);
      chk($sformatf("row%0d", i), {lx, sn, irq, sv, ovr, oc},
          {tbl[i].e_lx, tbl[i].e_sn, tbl[i].e_irq, tbl[i].e_val,
           tbl[i].e_ovr, tbl[i].e_cnt});
    end

    // Capture, then scramble inputs: snapshot must hold
    lxi = 8'h12; sni = 8'hA5;
    step(1, 0, 0);
    hi = irq; bad = 0;
    lxi = 8'hFF; lyi = 8'hFF; bii = 8'hFF;
    sni = 8'hFF; lmi = 8'hFF; rmi = 8'hFF;
    for (int i = 0; i < 100; i++) begin
      step(0, logic'(i == 10), 0);
      hi += irq;
      if ({lx, ly, bi, sn, lm, rm} !==
          {8'h12, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00}) bad++;
    end
    chk("hold_snapshot", bad, 0);
    chk("irq_width", hi, 2);
    chk("hold_model", dut_vec(), exp_vec());

    // Overrun saturation and ClearOvr collision
    step(1, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 0);
    chk("ocnt_sat", {ovr, oc}, {1'b1, 8'd255});
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    chk("clr_vs_ovr", {ovr, oc}, {1'b1, 8'd1});
    chk("sat_model", dut_vec(), exp_vec());

    step(0, 1, 0);
    step(0, 0, 0);
`ifdef BOT_SNAP_TIMEOUT_EN
    n = 0;
    while (!to && n < 200) begin step(0, 0, 0); n++; end
    chk("to_latency", n, 52);
    chk("to_irq_low", irq, 1'b0);
    lxi = 8'h77;
    step(1, 0, 0);
    chk("post_to_capture", {lx, irq, oc, to}, {8'h77, 1'b1, 8'd1, 1'b1});
`else
    n = 0;
    repeat (10000) begin step(0, 0, 0); n += to; end
    chk("no_timeout", n, 0);
    lxi = 8'h77;
    step(1, 0, 0);
    chk("still_waiting", {lx, irq, oc, to}, {8'hFF, 1'b0, 8'd2, 1'b0});
`endif
    step(0, 1, 0);
    chk("to_model", dut_vec(), exp_vec());

    // Asynchronous reset mid-IRQ with a pending capture
    do_reset();
    lxi = 8'h5A;
    step(1, 0, 0);
    step(1, 0, 0);
    #2 rst = 0;
    #1 chk("async_reset", dut_vec(), 60'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    repeat (5) step(0, 0, 0);
    chk("no_capture_after_reset", dut_vec(), 60'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lxi = 8'($urandom); lyi = 8'($urandom); bii = 8'($urandom);
      sni = 8'($urandom); lmi = 8'($urandom); rmi = 8'($urandom);
      step(logic'($urandom_range(99) < 20),
           logic'($urandom_range(99) < ((i < 1500) ? 8 : 1)),
           logic'($urandom_range(99) < 3));
      chk("rand", dut_vec(), exp_vec());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
